// File: rtl/pe_mac_dbuf_if.sv
// pe_mac_dbuf_if: dataflow, window-control and column-chain signals of one systolic MAC processing element
interface pe_mac_dbuf_if #(
  parameter int DW = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 9
);
  logic en_synch;
  logic in_valid;
  logic signed [DW-1:0] in_data;
  logic signed [DW-1:0] in_weight;
  logic [CNT_W-1:0] kernel_len;
  logic signed [DW-1:0] out_in;
  logic signed [DW-1:0] out_weight;
  logic out_valid;
  logic sel;
  logic signed [ACC_W-1:0] in_pre;
  logic in_pre_valid;
  logic res_take;
  logic signed [ACC_W-1:0] out_data;
  logic out_data_valid;
  logic overrun;
  logic sat_flag;
  modport master (
    output en_synch, in_valid, in_data, in_weight, kernel_len, sel, in_pre, in_pre_valid, res_take,
    input out_in, out_weight, out_valid, out_data, out_data_valid, overrun, sat_flag
  );
  modport slave (
    input en_synch, in_valid, in_data, in_weight, kernel_len, sel, in_pre, in_pre_valid, res_take,
    output out_in, out_weight, out_valid, out_data, out_data_valid, overrun, sat_flag
  );
endinterface

// File: rtl/pe_mac_dbuf.sv
// pe_mac_dbuf: output-stationary systolic MAC PE with double-buffered result; define PE_MAC_SAT_EN for saturating accumulation
module pe_mac_dbuf #(
  parameter int DW = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 9,
  parameter int MUL_LAT = 2
) (
  input logic clk,
  input logic rst,
  pe_mac_dbuf_if.slave io
);
  logic en;
  logic fv_q, fv_d;
  logic signed [DW-1:0] fi_q, fi_d, fw_q, fw_d;
  logic signed [ACC_W-1:0] pp_q [MUL_LAT];
  logic signed [ACC_W-1:0] pp_d [MUL_LAT];
  logic pv_q [MUL_LAT];
  logic pv_d [MUL_LAT];
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, len_eff, len_cur;
  logic signed [ACC_W-1:0] acc_q, acc_d, res_q, res_d, base, tail, sum, ext;
  logic signed [2*DW-1:0] mul;
  logic res_full_q, res_full_d, ovr_q, ovr_d, tail_v, done, take;
  assign en = io.en_synch;
  assign mul = io.in_data * io.in_weight;
  assign ext = ACC_W'(mul);
  assign tail = pp_q[MUL_LAT-1];
  assign tail_v = pv_q[MUL_LAT-1];
  assign len_eff = io.kernel_len == '0 ? CNT_W'(1) : io.kernel_len;
  assign len_cur = cnt_q == '0 ? len_eff : len_q;
  assign done = tail_v & (cnt_q == len_cur - CNT_W'(1));
  assign take = io.res_take & io.sel & res_full_q;
  assign base = cnt_q == '0 ? '0 : acc_q;
`ifdef PE_MAC_SAT_EN
  logic signed [ACC_W:0] wide;
  logic ovf, sat_q, sat_d;
  assign wide = {base[ACC_W-1], base} + {tail[ACC_W-1], tail};
  assign ovf = wide[ACC_W] ^ wide[ACC_W-1];
  assign sum = ovf ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
  always_comb sat_d = sat_q | (en & tail_v & ovf);
  always_ff @(posedge clk) sat_q <= rst ? 1'b0 : sat_d;
  assign io.sat_flag = sat_q;
`else
  assign sum = base + tail;
  assign io.sat_flag = 1'b0;
`endif
  always_comb begin
    pp_d = pp_q;
    pv_d = pv_q;
    if (en) begin
      pp_d[0] = io.in_valid ? ext : '0;
      pv_d[0] = io.in_valid;
      for (int i = 1; i < MUL_LAT; i++) begin
        pp_d[i] = pp_q[i-1];
        pv_d[i] = pv_q[i-1];
      end
    end
  end
  always_comb begin
    fv_d = en ? io.in_valid : fv_q;
    fi_d = en ? (io.in_valid ? io.in_data : '0) : fi_q;
    fw_d = en ? (io.in_valid ? io.in_weight : '0) : fw_q;
    acc_d = (en & tail_v) ? sum : acc_q;
    cnt_d = (en & tail_v) ? (done ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    len_d = (en & tail_v & (cnt_q == '0)) ? len_eff : len_q;
    res_d = (en & done) ? sum : res_q;
    res_full_d = en ? (done | (res_full_q & ~take)) : res_full_q;
    ovr_d = ovr_q | (en & done & res_full_q & ~take);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q <= 1'b0;
      fi_q <= '0;
      fw_q <= '0;
      pp_q <= '{default: '0};
      pv_q <= '{default: 1'b0};
      cnt_q <= '0;
      len_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      res_full_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      fv_q <= fv_d;
      fi_q <= fi_d;
      fw_q <= fw_d;
      pp_q <= pp_d;
      pv_q <= pv_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      acc_q <= acc_d;
      res_q <= res_d;
      res_full_q <= res_full_d;
      ovr_q <= ovr_d;
    end
  end
  assign io.out_valid = fv_q;
  assign io.out_in = fi_q;
  assign io.out_weight = fw_q;
  assign io.out_data = io.sel ? res_q : io.in_pre;
  assign io.out_data_valid = io.sel ? res_full_q : io.in_pre_valid;
  assign io.overrun = ovr_q;
endmodule

// File: tb/tb_pe_mac_dbuf.sv
// tb_pe_mac_dbuf: table-driven, directed and randomized checks of pe_mac_dbuf against a scheduled-product reference model
module tb_pe_mac_dbuf;
  localparam int DW = 8;
  localparam int ACC_W = 24;
  localparam int CNT_W = 9;
  localparam int MUL_LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pe_mac_dbuf_if #(.DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W)) ifa();
  pe_mac_dbuf_if #(.DW(DW), .ACC_W(16), .CNT_W(CNT_W)) ifb();
  pe_mac_dbuf #(.DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .io(ifa.slave));
  pe_mac_dbuf #(.DW(DW), .ACC_W(16), .CNT_W(CNT_W), .MUL_LAT(MUL_LAT)) dut16 (.clk(clk), .rst(rst), .io(ifb.slave));
  assign ifb.en_synch = ifa.en_synch;
  assign ifb.in_valid = ifa.in_valid;
  assign ifb.in_data = ifa.in_data;
  assign ifb.in_weight = ifa.in_weight;
  assign ifb.kernel_len = ifa.kernel_len;
  assign ifb.sel = ifa.sel;
  assign ifb.in_pre = ifa.in_pre[15:0];
  assign ifb.in_pre_valid = ifa.in_pre_valid;
  assign ifb.res_take = ifa.res_take;
  typedef struct {int due; longint p;} mp_t;
  typedef struct {int klen; int a; int b; int n; int exp;} vec_t;
  mp_t pipe[$];
  int adv, wcnt, wlen;
  longint wsum;
  logic signed [ACC_W-1:0] m_res;
  bit m_full, m_ovr, m_fv;
  logic signed [DW-1:0] m_fd, m_fw;
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(string n, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask
  task automatic m_reset();
    pipe.delete();
    adv = 0; wcnt = 0; wlen = 0; wsum = 0;
    m_res = '0; m_full = 0; m_ovr = 0; m_fv = 0; m_fd = '0; m_fw = '0;
  endtask
  task automatic model_edge();
    bit take, done;
    longint p;
    take = ifa.res_take && ifa.sel && m_full;
    done = 0;
    if (rst) m_reset();
    else if (ifa.en_synch) begin
      adv++;
      m_fv = ifa.in_valid;
      m_fd = ifa.in_valid ? ifa.in_data : '0;
      m_fw = ifa.in_valid ? ifa.in_weight : '0;
      if (pipe.size() > 0 && pipe[0].due == adv) begin
        p = pipe.pop_front().p;
        if (wcnt == 0) begin
          wlen = ifa.kernel_len == 0 ? 1 : int'(ifa.kernel_len);
          wsum = 0;
        end
        wsum += p;
        wcnt++;
        if (wcnt == wlen) begin
          done = 1;
          wcnt = 0;
        end
      end
      if (done) begin
        if (m_full && !take) m_ovr = 1;
        m_res = wsum[ACC_W-1:0];
        m_full = 1;
      end else if (take) m_full = 0;
      if (ifa.in_valid) pipe.push_back('{adv + MUL_LAT, longint'(ifa.in_data) * longint'(ifa.in_weight)});
    end
  endtask
  task automatic check_all();
    chk("out_valid", ifa.out_valid, m_fv);
    chk("out_in", ifa.out_in, m_fd);
    chk("out_weight", ifa.out_weight, m_fw);
    chk("out_data", ifa.out_data, ifa.sel ? longint'(m_res) : longint'(ifa.in_pre));
    chk("out_data_valid", ifa.out_data_valid, ifa.sel ? m_full : ifa.in_pre_valid);
    chk("overrun", ifa.overrun, m_ovr);
    chk("sat_flag", ifa.sat_flag, 0);
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  task automatic idle();
    ifa.en_synch = 1; ifa.in_valid = 0; ifa.in_data = '0; ifa.in_weight = '0;
    ifa.sel = 1; ifa.in_pre = '0; ifa.in_pre_valid = 0; ifa.res_take = 0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic feed(int a, int b, int n);
    for (int i = 0; i < n; i++) begin
      ifa.in_valid = 1; ifa.in_data = DW'(a); ifa.in_weight = DW'(b);
      tick();
    end
    ifa.in_valid = 0; ifa.in_data = '0; ifa.in_weight = '0;
  endtask
  task automatic wait_res(input int max, output int cyc);
    cyc = 0;
    while (!ifa.out_data_valid && cyc < max) begin
      tick();
      cyc++;
    end
  endtask
  vec_t vt[$];
  longint got[$];
  int at[$];
  int w, cnt;
  logic signed [DW-1:0] s_oi, s_ow;
  logic s_ov, s_dv;
  initial begin
    vt = '{'{9, 3, -2, 9, -54}, '{4, 1, 1, 4, 4}, '{4, 2, 3, 4, 24}, '{2, 7, 1, 2, 14},
           '{0, 5, -7, 1, -35}, '{1, -128, -128, 1, 16384}, '{3, -128, 127, 3, -48768}, '{5, 127, 127, 5, 80645}};
    idle();
    ifa.kernel_len = 1;
    rst = 1;
    tick();
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_data_valid", ifa.out_data_valid, 0);
    chk("rst_out_data", ifa.out_data, 0);
    chk("rst_overrun", ifa.overrun, 0);
    rst = 0;
    foreach (vt[k]) begin
      do_reset();
      ifa.kernel_len = CNT_W'(vt[k].klen);
      cnt = 0;
      for (int i = 0; i < vt[k].n; i++) begin
        ifa.in_valid = 1; ifa.in_data = DW'(vt[k].a); ifa.in_weight = DW'(vt[k].b);
        tick();
        cnt++;
        if (i == 0) begin
          chk("vec_fwd_in", ifa.out_in, vt[k].a);
          chk("vec_fwd_weight", ifa.out_weight, vt[k].b);
        end
      end
      idle();
      wait_res(20, w);
      chk("vec_latency", cnt + w, MUL_LAT + vt[k].n);
      chk("vec_result", ifa.out_data, vt[k].exp);
    end
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      ifa.kernel_len = 4;
      got.delete();
      at.delete();
      for (int c = 0; c < 20; c++) begin
        ifa.in_valid = c < 8;
        ifa.in_data = c < 8 ? (c < 4 ? DW'(1) : DW'(2)) : '0;
        ifa.in_weight = c < 8 ? (c < 4 ? DW'(1) : DW'(3)) : '0;
        ifa.res_take = mode == 0 && ifa.out_data_valid;
        if (mode == 0 && ifa.out_data_valid) begin
          got.push_back(ifa.out_data);
          at.push_back(c);
        end
        tick();
      end
      idle();
      if (mode == 0) begin
        chk("b2b_count", got.size(), 2);
        if (got.size() == 2) begin
          chk("b2b_first", got[0], 4);
          chk("b2b_second", got[1], 24);
          chk("b2b_first_cycle", at[0], MUL_LAT + 4);
          chk("b2b_gap", at[1] - at[0], 4);
        end
        chk("b2b_overrun", ifa.overrun, 0);
      end else begin
        chk("ovr_result", ifa.out_data, 24);
        chk("ovr_valid", ifa.out_data_valid, 1);
        chk("ovr_flag", ifa.overrun, 1);
      end
    end
    do_reset();
    ifa.kernel_len = 1;
    ifa.res_take = 1;
    ifa.in_valid = 1; ifa.in_data = 1; ifa.in_weight = 1;
    tick();
    ifa.in_data = 2; ifa.in_weight = 2;
    tick();
    ifa.in_valid = 0; ifa.in_data = '0; ifa.in_weight = '0;
    tick();
    chk("coin_first", ifa.out_data, 1);
    tick();
    ifa.res_take = 0;
    chk("coin_result", ifa.out_data, 4);
    chk("coin_valid", ifa.out_data_valid, 1);
    chk("coin_overrun", ifa.overrun, 0);
    do_reset();
    ifa.kernel_len = 4;
    feed(5, 5, 2);
    s_oi = ifa.out_in; s_ow = ifa.out_weight; s_ov = ifa.out_valid; s_dv = ifa.out_data_valid;
    ifa.en_synch = 0; ifa.in_valid = 1; ifa.in_data = -3; ifa.in_weight = 9; ifa.res_take = 1;
    repeat (5) begin
      tick();
      chk("stall_out_in", ifa.out_in, s_oi);
      chk("stall_out_weight", ifa.out_weight, s_ow);
      chk("stall_out_valid", ifa.out_valid, s_ov);
      chk("stall_data_valid", ifa.out_data_valid, s_dv);
    end
    idle();
    feed(5, 5, 2);
    wait_res(20, w);
    chk("stall_result", ifa.out_data, 100);
    do_reset();
    ifa.kernel_len = 4;
    feed(-128, -128, 4);
    w = 0;
    while (!ifb.out_data_valid && w < 20) begin
      tick();
      w++;
    end
    chk("w16_valid", ifb.out_data_valid, 1);
`ifdef PE_MAC_SAT_EN
    chk("w16_result", ifb.out_data, 32767);
    chk("w16_sat", ifb.sat_flag, 1);
`else
    chk("w16_result", ifb.out_data, 0);
    chk("w16_sat", ifb.sat_flag, 0);
`endif
    ifa.sel = 0; ifa.in_pre = 24'h00ABCD; ifa.in_pre_valid = 1;
    #1;
    chk("mux_pre_data", ifa.out_data, 24'h00ABCD);
    chk("mux_pre_valid", ifa.out_data_valid, 1);
    idle();
    do_reset();
    ifa.kernel_len = 4;
    feed(9, 9, 3);
    rst = 1;
    tick();
    rst = 0;
    ifa.kernel_len = 2;
    feed(7, 1, 2);
    wait_res(20, w);
    chk("rst_mid_result", ifa.out_data, 14);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ifa.en_synch = $urandom_range(0, 9) != 0;
      ifa.in_valid = $urandom_range(0, 3) != 0;
      ifa.in_data = DW'($urandom);
      ifa.in_weight = DW'($urandom);
      if ($urandom_range(0, 19) == 0) ifa.kernel_len = CNT_W'($urandom_range(0, 5));
      ifa.sel = $urandom_range(0, 3) != 0;
      ifa.res_take = 1'($urandom);
      ifa.in_pre = ACC_W'($urandom);
      ifa.in_pre_valid = 1'($urandom);
      rst = $urandom_range(0, 199) == 0;
      tick();
    end
    rst = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pe_mac_dbuf.md
Name: pe_mac_dbuf

Overview:
Next-generation output-stationary systolic processing element. It forwards activation and weight with a valid bit to its neighbours and runs a parametrised pipelined signed multiply. It accumulates over a runtime-programmable window into a parametrised-width accumulator, then moves the finished sum into a double-buffered result register. The result drains through the column output chain while the next window accumulates, so the array does not stall between output pixels.

Parameters:
DW, 8, signed width of activation and weight
ACC_W, 24, signed accumulator/result width (must be >= 2*DW)
CNT_W, 9, width of window counter and kernel_len
MUL_LAT, 2, multiplier pipeline depth in cycles (>= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en_synch  in  1  global advance; 0 = whole PE holds state
in_valid  in  1  in_data/in_weight valid this cycle
in_data  in  DW  signed activation from left neighbour
in_weight  in  DW  signed weight from upper neighbour
kernel_len  in  CNT_W  MACs per window; 0 treated as 1
out_in  out  DW  forwarded activation
out_weight  out  DW  forwarded weight
out_valid  out  1  forwarded valid
sel  in  1  1 = drive own result on chain, 0 = pass in_pre
in_pre  in  ACC_W  result from previous PE in column chain
in_pre_valid  in  1  in_pre valid
res_take  in  1  downstream consumed own result this cycle
out_data  out  ACC_W  column chain output
out_data_valid  out  1  out_data valid
overrun  out  1  sticky: unconsumed result overwritten
sat_flag  out  1  sticky saturation flag (0 when SAT_EN is absent)

Behaviour:
- Reset (rst=1 at clk edge): all registers 0, including the forward regs, multiplier pipe, cnt, acc, res, res_full, overrun and sat_flag. Reset mid-window discards partial sums.
- en_synch=0: every register holds its value; outputs stay stable; res_take is ignored.
- Forwarding, 1-cycle latency when en_synch=1:
  - out_valid <= in_valid
  - out_in <= in_valid ? in_data : 0
  - out_weight <= in_valid ? in_weight : 0
- Multiplier:
  - product = in_data*in_weight, signed 2*DW, sign-extended to ACC_W.
  - The product and its valid bit emerge exactly MUL_LAT advancing cycles after sampling.
  - Invalid inputs yield product 0 with valid 0.
- Accumulator, on product valid:
  - acc_next = (cnt==0 ? 0 : acc) + product.
  - At cnt==0, kernel_len is latched into len_q; mid-window changes have no effect.
  - If cnt == len_q-1: res <= acc_next, res_full <= 1, cnt <= 0. Otherwise cnt <= cnt+1.
  - No valid product: acc and cnt hold. Gaps inside a window are allowed.
- Result buffer:
  - If res_take=1, sel=1 and res_full=1: res_full clears, unless a window completes in the same cycle. In that case the new result loads and res_full stays 1.
  - If a window completes while res_full=1 and no take occurs: res is overwritten and overrun <= 1 (sticky until rst).
- Output mux, combinational:
  - sel=1: out_data = res, out_data_valid = res_full.
  - sel=0: out_data = in_pre, out_data_valid = in_pre_valid.
- Arithmetic without SAT_EN: two's-complement wrap modulo 2^ACC_W.

Optional Feature:
PE_MAC_SAT_EN
- Defined:
  - A positive accumulate overflow clamps to 2^(ACC_W-1)-1.
  - A negative overflow clamps to -2^(ACC_W-1).
  - sat_flag sets, sticky until rst.
  - Saturation applies per addition step.
- Undefined:
  - Wrap arithmetic.
  - sat_flag tied to 0.
  - No saturation logic is synthesised.

Test Plan:
- kernel_len=9, MUL_LAT=2; nine valid pairs (3,-2), one per cycle; sel=1, res_take=0 -> out_data_valid rises 2+9 cycles after the first pair; out_data=-54. out_in/out_weight mirror the inputs 1 cycle later.
- Back-to-back windows with kernel_len=4: pairs (1,1)x4 then (2,3)x4; res_take pulsed when res_full -> results 4 then 24. overrun=0, no bubble between windows.
- Same stream with res_take held 0 -> second window overwrites res=24, overrun=1. Window completion coinciding with res_take=1 -> res_full stays 1 with the new value.
- en_synch=0 for 5 cycles mid-window (after 2 of 4 MACs of (5,5)) -> all outputs frozen; on resume the final result is 100, identical to the unstalled run.
- DW=8, ACC_W=16, kernel_len=4, pairs (-128,-128)x4 -> without PE_MAC_SAT_EN result 0 (65536 wrapped); with it result 32767, sat_flag=1.
- sel=0 with in_pre=0x00ABCD, in_pre_valid=1 -> out_data=0x00ABCD combinationally. Assert rst mid-window -> next window with kernel_len=2, pairs (7,1)x2, gives 14 with no stale partial sum.
